// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus responder: bus bit positions, command
// classes, FSM states and small address-counter helpers.
package lcd_pkg;

    localparam int unsigned DATA_W     = 10;
    localparam int unsigned DB_W       = 8;
    localparam int unsigned AC_W       = 7;
    localparam int unsigned RS_BIT     = 9;
    localparam int unsigned RW_BIT     = 8;
    localparam logic [7:0]  CHAR_SPACE = 8'h20;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_CLR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISP,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGA,
        CMD_DDA
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR
    } state_e;

    // Command class is selected by the highest set bit of DB.
    function automatic cmd_e decode_cmd(input logic [DB_W-1:0] db);
        if (db[7])      return CMD_DDA;
        else if (db[6]) return CMD_CGA;
        else if (db[5]) return CMD_FUNC;
        else if (db[4]) return CMD_SHIFT;
        else if (db[3]) return CMD_DISP;
        else if (db[2]) return CMD_ENTRY;
        else if (db[1]) return CMD_HOME;
        else if (db[0]) return CMD_CLR;
        else            return CMD_NOP;
    endfunction

    // Step the address counter one place, wrapping within 0..depth-1.
    function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] a,
                                                input logic            inc,
                                                input int unsigned     depth);
        if (inc)
            return (32'(a) >= depth - 1) ? 7'd0 : a + 7'd1;
        else
            return (a == 7'd0) ? 7'(depth - 1) : a - 7'd1;
    endfunction

    // DDRAM address set: out-of-range values fold back by one depth.
    function automatic logic [AC_W-1:0] ac_fold(input logic [AC_W-1:0] a,
                                                input int unsigned     depth);
        return (32'(a) >= depth) ? 7'(32'(a) - depth) : a;
    endfunction

endpackage

// File: rtl/lcd_bus_responder_en_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus falling-edge
// detection of the synced enable; captured fields are last cycle's synced data.
module lcd_en_sync
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_accept,
    output logic              o_rs,
    output logic              o_rw,
    output logic [DB_W-1:0]   o_db,
    output logic              o_en_s,
    output logic              o_rs_s,
    output logic              o_rw_s
);

    logic              r_en_m;
    logic              r_en_s;
    logic              r_en_d;
    logic [DATA_W-1:0] r_data_m;
    logic [DATA_W-1:0] r_data_s;
    logic [DATA_W-1:0] r_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_m   <= 1'b0;
            r_en_s   <= 1'b0;
            r_en_d   <= 1'b0;
            r_data_m <= '0;
            r_data_s <= '0;
            r_data_d <= '0;
        end else begin
            r_en_m   <= i_en;
            r_en_s   <= r_en_m;
            r_en_d   <= r_en_s;
            r_data_m <= i_data;
            r_data_s <= r_data_m;
            r_data_d <= r_data_s;
        end
    end

    assign o_accept = r_en_d & ~r_en_s;
    assign o_rs     = r_data_d[RS_BIT];
    assign o_rw     = r_data_d[RW_BIT];
    assign o_db     = r_data_d[DB_W-1:0];
    assign o_en_s   = r_en_s;
    assign o_rs_s   = r_data_s[RS_BIT];
    assign o_rw_s   = r_data_s[RW_BIT];

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style display-side responder: decodes bus commands, holds DDRAM,
// tracks address counter and busy time, answers reads, exposes a debug port.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH        = 80,
    parameter int unsigned BUSY_CYCLES  = 37,
    parameter int unsigned CLEAR_CYCLES = 1520
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] lcd_data,
    input  logic              lcd_en,
    output logic [DB_W-1:0]   lcd_rdata,
    output logic              lcd_rdata_oe,
    output logic              busy,
    output logic [AC_W-1:0]   ac,
    output logic              disp_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              entry_inc,
    output logic              entry_shift,
    output logic              func_8bit,
    output logic              func_2line,
    output logic              overrun,
    input  logic [AC_W-1:0]   dbg_addr,
    output logic [DB_W-1:0]   dbg_char
);

    localparam int unsigned CNT_W = $clog2(CLEAR_CYCLES + 1);

    logic            w_accept;
    logic            w_rs;
    logic            w_rw;
    logic [DB_W-1:0] w_db;
    logic            w_en_s;
    logic            w_rs_s;
    logic            w_rw_s;
    cmd_e            w_cmd;

    logic            w_we;
    logic [AC_W-1:0] w_waddr;
    logic [DB_W-1:0] w_wdata;

    state_e          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [AC_W-1:0] r_fill;
    logic            r_busy;
    logic [AC_W-1:0] r_ac;
    logic            r_disp_on;
    logic            r_cursor_on;
    logic            r_blink_on;
    logic            r_entry_inc;
    logic            r_entry_shift;
    logic            r_func_8bit;
    logic            r_func_2line;
    logic            r_overrun;
    logic [DB_W-1:0] r_rdata;
    logic            r_rdata_oe;
    logic [DB_W-1:0] r_dbg;
    logic [DB_W-1:0] r_mem [DEPTH];

    lcd_en_sync u_sync (
        .clk      (clk),
        .rst_n    (reset),
        .i_en     (lcd_en),
        .i_data   (lcd_data),
        .o_accept (w_accept),
        .o_rs     (w_rs),
        .o_rw     (w_rw),
        .o_db     (w_db),
        .o_en_s   (w_en_s),
        .o_rs_s   (w_rs_s),
        .o_rw_s   (w_rw_s)
    );

    assign w_cmd = decode_cmd(w_db);

    // DDRAM write port: fill during CLEAR, data write when idle.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_fill;
        w_wdata = CHAR_SPACE;
        if (r_state == CLEAR) begin
            w_we = 1'b1;
        end else if (r_state == IDLE && w_accept && w_rs && !w_rw) begin
            w_we    = 1'b1;
            w_waddr = r_ac;
            w_wdata = w_db;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    // Debug read is write-first so a same-cycle fill is visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_dbg <= '0;
        else if (32'(dbg_addr) >= DEPTH)
            r_dbg <= CHAR_SPACE;
        else if (w_we && w_waddr == dbg_addr)
            r_dbg <= w_wdata;
        else
            r_dbg <= r_mem[dbg_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata    <= '0;
            r_rdata_oe <= 1'b0;
        end else begin
            r_rdata_oe <= w_en_s & w_rw_s;
            if (w_en_s && w_rw_s)
                r_rdata <= w_rs_s ? r_mem[r_ac] : {r_busy, r_ac};
        end
    end

    // Control FSM: command decode, busy timing and the clear fill sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= CLEAR;
            r_cnt         <= '0;
            r_fill        <= '0;
            r_busy        <= 1'b1;
            r_ac          <= '0;
            r_disp_on     <= 1'b0;
            r_cursor_on   <= 1'b0;
            r_blink_on    <= 1'b0;
            r_entry_inc   <= 1'b1;
            r_entry_shift <= 1'b0;
            r_func_8bit   <= 1'b1;
            r_func_2line  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_rw && w_rs) begin
                        r_ac    <= ac_step(r_ac, r_entry_inc, DEPTH);
                        r_state <= EXEC;
                        r_busy  <= 1'b1;
                        r_cnt   <= CNT_W'(BUSY_CYCLES - 1);
                    end else if (w_accept && !w_rw) begin
                        if (w_cmd != CMD_NOP) begin
                            r_state <= EXEC;
                            r_busy  <= 1'b1;
                            r_cnt   <= CNT_W'(BUSY_CYCLES - 1);
                        end
                        case (w_cmd)
                            CMD_CLR: begin
                                r_state <= CLEAR;
                                r_fill  <= '0;
                            end
                            CMD_HOME: begin
                                r_ac  <= '0;
                                r_cnt <= CNT_W'(CLEAR_CYCLES - 1);
                            end
                            CMD_ENTRY: begin
                                r_entry_inc   <= w_db[1];
                                r_entry_shift <= w_db[0];
                            end
                            CMD_DISP: begin
                                r_disp_on   <= w_db[2];
                                r_cursor_on <= w_db[1];
                                r_blink_on  <= w_db[0];
                            end
                            CMD_SHIFT: begin
                                if (!w_db[3])
                                    r_ac <= ac_step(r_ac, w_db[2], DEPTH);
                            end
                            CMD_FUNC: begin
                                r_func_8bit  <= w_db[4];
                                r_func_2line <= w_db[3];
                            end
                            CMD_DDA: r_ac <= ac_fold(w_db[6:0], DEPTH);
                            default: ;
                        endcase
                    end else if (w_accept && w_rs) begin
                        r_ac <= ac_step(r_ac, r_entry_inc, DEPTH);
                    end
                end
                EXEC: begin
                    if (w_accept && !w_rw)
                        r_overrun <= 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                CLEAR: begin
                    if (w_accept)
                        r_overrun <= 1'b1;
                    if (r_fill == 7'(DEPTH - 1)) begin
                        r_state     <= EXEC;
                        r_cnt       <= CNT_W'(CLEAR_CYCLES - DEPTH - 1);
                        r_fill      <= '0;
                        r_ac        <= '0;
                        r_entry_inc <= 1'b1;
                    end else begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_busy  <= 1'b1;
                    r_fill  <= '0;
                end
            endcase
        end
    end

    assign lcd_rdata    = r_rdata;
    assign lcd_rdata_oe = r_rdata_oe;
    assign busy         = r_busy;
    assign ac           = r_ac;
    assign disp_on      = r_disp_on;
    assign cursor_on    = r_cursor_on;
    assign blink_on     = r_blink_on;
    assign entry_inc    = r_entry_inc;
    assign entry_shift  = r_entry_shift;
    assign func_8bit    = r_func_8bit;
    assign func_2line   = r_func_2line;
    assign overrun      = r_overrun;
    assign dbg_char     = r_dbg;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: bus transfers, busy timing, DDRAM
// contents through the debug port, status/data reads and mid-operation reset.
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] lcd_data = '0;
    logic       lcd_en = 1'b0;
    logic [7:0] lcd_rdata;
    logic       lcd_rdata_oe;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on;
    logic       entry_inc, entry_shift;
    logic       func_8bit, func_2line;
    logic       overrun;
    logic [6:0] dbg_addr = '0;
    logic [7:0] dbg_char;

    int n_vec = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    lcd_bus_responder dut (
        .clk          (clk),
        .reset        (reset),
        .lcd_data     (lcd_data),
        .lcd_en       (lcd_en),
        .lcd_rdata    (lcd_rdata),
        .lcd_rdata_oe (lcd_rdata_oe),
        .busy         (busy),
        .ac           (ac),
        .disp_on      (disp_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .entry_inc    (entry_inc),
        .entry_shift  (entry_shift),
        .func_8bit    (func_8bit),
        .func_2line   (func_2line),
        .overrun      (overrun),
        .dbg_addr     (dbg_addr),
        .dbg_char     (dbg_char)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic rs, input logic rw, input logic [7:0] db);
        @(negedge clk);
        lcd_data = {rs, rw, db};
        lcd_en   = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en   = 1'b0;
    endtask

    // Count negedge samples of busy=1 for the transfer just issued.
    task automatic busy_len(output int cnt);
        cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    task automatic run_cmd(input string tag, input logic rs, input logic [7:0] db, input int exp_len);
        int len;
        pulse(rs, 1'b0, db);
        busy_len(len);
        chk(tag, 32'(len), 32'(exp_len));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 32'(0));
    endtask

    task automatic dbg_rd(input logic [6:0] addr, input logic [7:0] exp);
        @(negedge clk);
        dbg_addr = addr;
        @(negedge clk);
        chk($sformatf("dbg[%0d]", addr), 32'(dbg_char), 32'(exp));
    endtask

    task automatic rd(input string tag, input logic rs, input logic [7:0] exp);
        @(negedge clk);
        lcd_data = {rs, 1'b1, 8'h00};
        lcd_en   = 1'b1;
        repeat (4) @(negedge clk);
        chk({tag, "_oe"}, 32'(lcd_rdata_oe), 32'(1));
        chk({tag, "_data"}, 32'(lcd_rdata), 32'(exp));
        lcd_en = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_oe_off"}, 32'(lcd_rdata_oe), 32'(0));
    endtask

    task automatic count_init(input string tag);
        int k = 0;
        while (busy && k < 4000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(k), 32'(1520));
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_ac", 32'(ac), 32'(0));
        chk("rst_disp", 32'({disp_on, cursor_on, blink_on}), 32'(0));
        chk("rst_entry", 32'({entry_inc, entry_shift}), 32'(2));
        chk("rst_func", 32'({func_8bit, func_2line}), 32'(2));
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_rdata", 32'({lcd_rdata_oe, lcd_rdata}), 32'(0));
        chk("rst_dbg", 32'(dbg_char), 32'(0));

        // Power-up clear
        reset = 1'b1;
        count_init("init_busy_len");
        chk("init_ac", 32'(ac), 32'(0));
        for (int a = 0; a < 80; a++) dbg_rd(7'(a), 8'h20);
        dbg_rd(7'd100, 8'h20);

        // Set address, write two characters
        run_cmd("len_dda5", 1'b0, 8'h85, 37);
        chk("ac_dda5", 32'(ac), 32'(5));
        run_cmd("len_wr41", 1'b1, 8'h41, 37);
        run_cmd("len_wr42", 1'b1, 8'h42, 37);
        chk("ac_after_wr", 32'(ac), 32'(7));
        dbg_rd(7'd5, 8'h41);
        dbg_rd(7'd6, 8'h42);

        // Decrement mode with wrap below zero
        run_cmd("len_entry", 1'b0, 8'h04, 37);
        chk("entry_dec", 32'({entry_inc, entry_shift}), 32'(0));
        run_cmd("len_dda0", 1'b0, 8'h80, 37);
        run_cmd("len_wr5a", 1'b1, 8'h5A, 37);
        dbg_rd(7'd0, 8'h5A);
        chk("ac_wrap_dec", 32'(ac), 32'(79));

        // Data read steps ac (decrement) without adding busy time
        run_cmd("len_dda5b", 1'b0, 8'h85, 37);
        rd("rd_data", 1'b1, 8'h41);
        chk("rd_data_ac", 32'(ac), 32'(4));
        chk("rd_data_busy", 32'(busy), 32'(0));

        // Address fold, cursor shift, function set, home
        run_cmd("len_dda_fold", 1'b0, 8'hE4, 37);
        chk("ac_fold", 32'(ac), 32'(20));
        run_cmd("len_shr", 1'b0, 8'h14, 37);
        chk("ac_shr", 32'(ac), 32'(21));
        run_cmd("len_shl", 1'b0, 8'h10, 37);
        chk("ac_shl", 32'(ac), 32'(20));
        run_cmd("len_dshift", 1'b0, 8'h1C, 37);
        chk("ac_dshift", 32'(ac), 32'(20));
        run_cmd("len_func", 1'b0, 8'h38, 37);
        chk("func", 32'({func_8bit, func_2line}), 32'(3));
        run_cmd("len_home", 1'b0, 8'h02, 1520);
        chk("ac_home", 32'(ac), 32'(0));
        chk("no_overrun_yet", 32'(overrun), 32'(0));

        // Clear while busy is ignored and flags overrun
        pulse(1'b0, 1'b0, 8'h0F);
        repeat (10) @(negedge clk);
        pulse(1'b0, 1'b0, 8'h01);
        wait_idle("idle_after_disp");
        chk("disp_flags", 32'({disp_on, cursor_on, blink_on}), 32'(7));
        chk("overrun_set", 32'(overrun), 32'(1));
        dbg_rd(7'd0, 8'h5A);
        dbg_rd(7'd5, 8'h41);

        // Status read while busy
        pulse(1'b0, 1'b0, 8'h92);
        repeat (4) @(negedge clk);
        rd("rd_status", 1'b0, 8'h92);
        chk("rd_status_ac", 32'(ac), 32'(8'h12));
        wait_idle("idle_after_status");

        // Reset in the middle of EXEC
        run_cmd("len_dda0b", 1'b0, 8'h80, 37);
        pulse(1'b1, 1'b0, 8'h33);
        repeat (6) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'(1));
        dbg_rd(7'd0, 8'h33);
        reset = 1'b0;
        #1;
        chk("rst2_busy", 32'(busy), 32'(1));
        chk("rst2_ac", 32'(ac), 32'(0));
        chk("rst2_disp", 32'({disp_on, cursor_on, blink_on}), 32'(0));
        chk("rst2_entry", 32'({entry_inc, entry_shift}), 32'(2));
        chk("rst2_func", 32'({func_8bit, func_2line}), 32'(2));
        chk("rst2_overrun", 32'(overrun), 32'(0));
        chk("rst2_dbg", 32'(dbg_char), 32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        count_init("reinit_busy_len");
        dbg_rd(7'd0, 8'h20);
        dbg_rd(7'd5, 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
